// File: rtl/reg_mux_if.sv
// Request/result handshake bundle for reg_mux: flattened channel bus and select in,
// registered selected data with an out-of-range flag out.
interface reg_mux_if #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 10,
    parameter int unsigned SEL_W    = 4
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_err;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/reg_mux.sv
// Registered channel multiplexer with a one-entry valid/ready output stage.
// Optional macro REG_MUX_ERR_CNT_EN adds a saturating 8-bit out-of-range counter (err_cnt).
module reg_mux #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 10,
    parameter int unsigned SEL_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    reg_mux_if.slave        bus
`ifdef REG_MUX_ERR_CNT_EN
    ,
    output logic [7:0]      err_cnt
`endif
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             err_q;
    logic             err_d;
    logic             accept;

    // Channel select; any index with no matching channel yields zero data and an error.
    always_comb begin
        data_d = '0;
        err_d  = 1'b1;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                data_d = bus.in_data[k*WIDTH +: WIDTH];
                err_d  = 1'b0;
            end
        end
    end

    assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Output stage: refill takes precedence over drain so a full stage streams one result per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            state_q <= FULL;
            data_q  <= data_d;
            err_q   <= err_d;
        end else if (bus.out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_err   = err_q;
    assign bus.out_valid = (state_q == FULL);

`ifdef REG_MUX_ERR_CNT_EN
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && err_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_reg_mux.sv
// Self-checking bench for reg_mux (WIDTH=8, CHANNELS=10, SEL_W=4) against a queue-based model.
module tb_reg_mux;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 10;
    localparam int unsigned SEL_W    = 4;
    localparam logic [79:0] DATA_A   = 80'hC9_98_87_76_65_54_A5_32_21_10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

`ifdef REG_MUX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    reg_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef REG_MUX_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Model: at most one pending result; pushed on accept, popped when consumed.
    typedef struct {
        logic [7:0] d;
        logic       e;
    } res_t;

    res_t q[$];
    int   m_cnt = 0;

    always @(posedge clk) begin
        bit   acc;
        res_t r;
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            acc = bus.in_valid && ((q.size() == 0) || bus.out_ready);
            if ((q.size() != 0) && bus.out_ready) void'(q.pop_front());
            if (acc) begin
                if (int'(bus.in_sel) < int'(CHANNELS)) begin
                    r.d = 8'((bus.in_data >> (int'(bus.in_sel) * 8)) & 80'hFF);
                    r.e = 1'b0;
                end else begin
                    r.d = 8'h00;
                    r.e = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                q.push_back(r);
            end
        end
    end

    // Continuous compare, mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || bus.out_ready));
            check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_data", 32'(bus.out_data), 32'(q[0].d));
                check("out_err", 32'(bus.out_err), 32'(q[0].e));
            end
`ifdef REG_MUX_ERR_CNT_EN
            check("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic drive(input logic r, input logic v, input logic [3:0] s, input logic o);
        @(posedge clk);
        #3;
        rst          = r;
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.out_ready = o;
    endtask

    logic [7:0]  exp_ch [CHANNELS];
    logic [95:0] rnd;

    initial begin
        exp_ch = '{8'h10, 8'h21, 8'h32, 8'hA5, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hC9};
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        bus.in_data   = DATA_A;
        repeat (2) @(posedge clk);

        // Reset state and in_ready right after reset release
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_err", 32'(bus.out_err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single in-range request, one-cycle latency, then drained
        drive(1'b0, 1'b1, 4'd3, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        check("sel3_valid", 32'(bus.out_valid), 32'd1);
        check("sel3_data", 32'(bus.out_data), 32'hA5);
        check("sel3_err", 32'(bus.out_err), 32'd0);
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        check("sel3_drained", 32'(bus.out_valid), 32'd0);

        // Out-of-range request
`ifdef REG_MUX_ERR_CNT_EN
        check("cnt_before", 32'(err_cnt), 32'd0);
`endif
        drive(1'b0, 1'b1, 4'd12, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        check("sel12_valid", 32'(bus.out_valid), 32'd1);
        check("sel12_data", 32'(bus.out_data), 32'h00);
        check("sel12_err", 32'(bus.out_err), 32'd1);
`ifdef REG_MUX_ERR_CNT_EN
        check("cnt_after", 32'(err_cnt), 32'd1);
`endif

        // Hold while stalled, inputs toggling
        drive(1'b0, 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 4'(i * 3), 1'b0);
            rnd = {$urandom(), $urandom(), $urandom()};
            bus.in_data = rnd[79:0];
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", 32'(bus.out_data), 32'h65);
            check("stall_err", 32'(bus.out_err), 32'd0);
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        bus.in_data = DATA_A;
        drive(1'b0, 1'b0, 4'd0, 1'b1);

        // Back-to-back streaming of all channels, no bubbles
        for (int i = 0; i <= 10; i++) begin
            drive(1'b0, (i < 10), 4'(i % 10), 1'b1);
            @(negedge clk);
            if (i > 0) begin
                check("stream_valid", 32'(bus.out_valid), 32'd1);
                check("stream_data", 32'(bus.out_data), 32'(exp_ch[i-1]));
            end
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        check("stream_end", 32'(bus.out_valid), 32'd0);

        // Reset colliding with an accept while full
        drive(1'b0, 1'b1, 4'd1, 1'b0);
        drive(1'b1, 1'b1, 4'd2, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check("rstacc_valid", 32'(bus.out_valid), 32'd0);
        check("rstacc_data", 32'(bus.out_data), 32'd0);
        check("rstacc_err", 32'(bus.out_err), 32'd0);
`ifdef REG_MUX_ERR_CNT_EN
        check("rstacc_cnt", 32'(err_cnt), 32'd0);
`endif

        // out_ready while empty must not create a result
        drive(1'b0, 1'b0, 4'd4, 1'b1);
        drive(1'b0, 1'b0, 4'd4, 1'b1);
        @(negedge clk);
        check("idle_valid", 32'(bus.out_valid), 32'd0);

`ifdef REG_MUX_ERR_CNT_EN
        // Counter saturation
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 4'd15, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        check("cnt_sat", 32'(err_cnt), 32'd255);
        repeat (3) drive(1'b0, 1'b1, 4'd10, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        check("cnt_hold", 32'(err_cnt), 32'd255);
`endif

        drive(1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
